regfile_write_arbiter: RTL

Shares the register file's single write port (WriteReg/WriteData/RegWrite) between two write-back requesters: the ALU result path and the memory-load path. Each requester has a small FIFO. A round-robin arbiter issues at most one register-file write per cycle, and writes to register 0 are suppressed. A per-register pending scoreboard drives a read-hazard stall for the decode stage's two read addresses (Read1/Read2).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/wb_queue.sv | 74 +++++++
 rtl/regfile_write_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
//   NUM_REGS / REG_ADDR_W : architectural register count and address width
//   ZERO_REG              : hard-wired zero register; writes to it are dropped
//   req_e                 : write-back requester identity (arbiter last_grant)
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/wb_queue.sv
// Small circular FIFO holding pending write-back entries for one requester.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset (flushes the queue)
//   push, push_data: enqueue an entry (ignored when full)
//   pop            : dequeue the head (ignored when empty)
//   head           : current head entry, valid while !empty
//   empty, full    : derived from the registered occupancy count
module wb_queue #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit wrap so DEPTH need not be a power of two.
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU and load
// write-back paths, with a per-register pending scoreboard for decode stalls.
// Ports:
//   clock, reset_n                 : clock, synchronous active-low reset
//   alu_valid/ready/reg/data       : ALU write-back requester (valid/ready)
//   mem_valid/ready/reg/data       : load-path write-back requester
//   rf_write, rf_reg, rf_data      : RegWrite / WriteReg / WriteData
//   rd_a, rd_b                     : decode read addresses
//   stall                          : a read address has an outstanding write
//   pending                        : per-register outstanding-write flags
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [WIDTH-1:0]      alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [WIDTH-1:0]      mem_data,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_reg,
    output logic [WIDTH-1:0]      rf_data,
    input  logic [REG_ADDR_W-1:0] rd_a,
    input  logic [REG_ADDR_W-1:0] rd_b,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   pending
);

    localparam int unsigned EntryW = WIDTH + REG_ADDR_W;
    // Both FIFOs full plus the output register plus one in-flight accept.
    localparam int unsigned CntW = $clog2(2 * DEPTH + 2);

    logic [EntryW-1:0]     alu_head, mem_head;
    logic                  alu_empty, alu_full, mem_empty, mem_full;
    logic                  alu_push, mem_push;
    logic                  grant_alu, grant_mem;
    req_e                  last_grant_q;
    logic                  rf_write_q;
    logic [REG_ADDR_W-1:0] rf_reg_q;
    logic [WIDTH-1:0]      rf_data_q;
    logic [CntW-1:0]       cnt_q [NUM_REGS];
    logic [CntW-1:0]       cnt_d [NUM_REGS];

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;

    // Register-0 requests complete the handshake but are never enqueued.
    assign alu_push = alu_valid && alu_ready && (alu_reg != ZERO_REG);
    assign mem_push = mem_valid && mem_ready && (mem_reg != ZERO_REG);

    wb_queue #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_alu_q (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (alu_push),
        .push_data ({alu_reg, alu_data}),
        .pop       (grant_alu),
        .head      (alu_head),
        .empty     (alu_empty),
        .full      (alu_full)
    );

    wb_queue #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH)
    ) u_mem_q (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (mem_push),
        .push_data ({mem_reg, mem_data}),
        .pop       (grant_mem),
        .head      (mem_head),
        .empty     (mem_empty),
        .full      (mem_full)
    );

    // Round robin: on contention the requester not granted last wins.
    always_comb begin
        grant_alu = !alu_empty && (mem_empty || (last_grant_q == REQ_MEM));
        grant_mem = !mem_empty && !grant_alu;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rf_write_q   <= 1'b0;
            rf_reg_q     <= '0;
            rf_data_q    <= '0;
            last_grant_q <= REQ_MEM;
        end else begin
            rf_write_q <= grant_alu || grant_mem;
            if (grant_alu) begin
                rf_reg_q     <= alu_head[EntryW-1 -: REG_ADDR_W];
                rf_data_q    <= alu_head[WIDTH-1:0];
                last_grant_q <= REQ_ALU;
            end else if (grant_mem) begin
                rf_reg_q     <= mem_head[EntryW-1 -: REG_ADDR_W];
                rf_data_q    <= mem_head[WIDTH-1:0];
                last_grant_q <= REQ_MEM;
            end
        end
    end

    assign rf_write = rf_write_q;
    assign rf_reg   = rf_reg_q;
    assign rf_data  = rf_data_q;

    // Count up on accept, down when the register file commits the write.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r == 0) begin
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = cnt_q[r]
                         + CntW'(alu_push && (alu_reg == REG_ADDR_W'(r)))
                         + CntW'(mem_push && (mem_reg == REG_ADDR_W'(r)))
                         - CntW'(rf_write_q && (rf_reg_q == REG_ADDR_W'(r)));
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!reset_n) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    assign stall = pending[rd_a] || pending[rd_b];

endmodule
